rns_compare_9_8_7: RTL and testbench
====================================

Name: rns_compare_9_8_7

Overview:
Magnitude comparator for residue-number-system (RNS) operands in the moduli set {9, 8, 7}, giving a dynamic range of 0..503. Two RNS operands X and Y are compared as the integers they represent. The block drives one-hot less/equal/greater flags. It sits in the RNS datapath wherever sign, overflow or ordering decisions are needed, and is registered with a valid-qualified single-cycle latency.

Parameters:
None. The moduli 9, 8 and 7 are fixed by the module.

Ports:
clk     in   1  clock, rising edge
rst_n   in   1  asynchronous active-low reset
in_valid in  1  x*/y* are valid this cycle
x1      in   4  X mod 9, legal 0..8
x2      in   3  X mod 8, legal 0..7
x3      in   3  X mod 7, legal 0..6
y1      in   4  Y mod 9
y2      in   3  Y mod 8
y3      in   3  Y mod 7
le      out  1  X < Y
eq      out  1  X == Y
gr      out  1  X > Y
out_valid out 1 le/eq/gr correspond to an accepted input

Behaviour:
- Reset (rst_n=0, asynchronous): le=eq=gr=0 and out_valid=0, held until the first clk edge after release.
- Latency: inputs sampled on a clk rising edge with in_valid=1 produce le/eq/gr/out_valid=1 on the outputs after that same edge (1 cycle). There is no backpressure; one operand pair can be accepted every cycle.
- When in_valid=0 at an edge: out_valid goes to 0 and le/eq/gr hold their previous values.
- Exactly one of le/eq/gr is 1 whenever out_valid=1. All three are 0 only after reset and before the first accepted input.
- Conversion uses mixed-radix form, per operand: a1 = r9; a2 = (r8 − a1) mod 8; a3 = (4·(r7 − a1) − a2) mod 7. The value is V = a1 + 9·a2 + 72·a3, with 0 ≤ V ≤ 503.
  - 4 is the inverse of 9 mod 7; the inverse of 9 mod 8 and of 8 mod 7 is 1.
- Comparison: compare (a3, a2, a1) lexicographically, most-significant digit first. This is equivalent to an integer compare of V.
- All mod operations produce non-negative results. Negative intermediates wrap into 0..m−1.
- Combinational path from registers to registers only; no combinational input-to-output path.
- Reset asserted mid-stream clears the outputs immediately. Any in-flight sample is discarded.

Optional Feature:
Macro RNS_CMP_RANGE_CHECK_EN.
- Defined: adds output port `range_err` (1 bit, reset 0), registered with the same latency as le/eq/gr.
  - `range_err`=1 when any of x1, y1 > 8 or any of x3, y3 = 7.
  - On range_err=1: le=eq=gr=0 and out_valid=1.
- Not defined: there is no `range_err` port. Illegal residues are reduced before conversion: x1/y1 values 9..15 become value−9, and 7 on x3/y3 becomes 0.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> le=eq=gr=0 and out_valid=0 immediately; after release with in_valid=0, outputs stay 0.
- X=0 (0,0,0), Y=503 (8,7,6) -> next cycle le=1, eq=0, gr=0, out_valid=1. Swap the operands -> gr=1.
- X=Y=251 (8,3,6) -> eq=1, le=0, gr=0.
- X=251 (8,3,6), Y=252 (0,4,0) -> le=1. Swap -> gr=1.
- Exhaustive sweeps, back-to-back every cycle with a check one cycle later:
  - X=i, Y=503−i for i=0..503 -> gr=(i>503−i), eq=0, le=(i<503−i).
  - X=Y=i -> eq=1 for all i.
  - Mirrored sweep -> inverted flags.
- in_valid bubble: valid, invalid, valid -> out_valid pattern 1,0,1; flags hold during the bubble. With RNS_CMP_RANGE_CHECK_EN, x1=12 -> range_err=1 and le=eq=gr=0.

Source files
------------

// File: rtl/rns_compare_9_8_7.sv
// ============================================================================
// Module   : rns_compare_9_8_7
// Brief    : Registered magnitude comparator for RNS operands, moduli {9,8,7}.
//            Optional macro RNS_CMP_RANGE_CHECK_EN adds a range_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rns_compare_9_8_7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] x1,
    input  logic [2:0] x2,
    input  logic [2:0] x3,
    input  logic [3:0] y1,
    input  logic [2:0] y2,
    input  logic [2:0] y3,
    output logic       le,
    output logic       eq,
    output logic       gr,
`ifdef RNS_CMP_RANGE_CHECK_EN
    output logic       range_err,
`endif
    output logic       out_valid
);

    // Returns {a3, a2, a1}; fixed field widths make a plain unsigned compare
    // of the packed result identical to the lexicographic digit compare.
    function automatic logic [9:0] mixed_radix(input logic [3:0] r9,
                                               input logic [2:0] r8,
                                               input logic [2:0] r7);
        logic [3:0] a1;
        logic [2:0] a2;
        logic [2:0] a3;
        logic [2:0] r7n;
        logic [2:0] a1m7;
        logic [2:0] d;
        logic [2:0] e;
        logic [2:0] a2m7;
        a1   = (r9 > 4'd8) ? (r9 - 4'd9) : r9;
        r7n  = (r7 == 3'd7) ? 3'd0 : r7;
        a2   = r8 - a1[2:0];
        a1m7 = (a1 >= 4'd7) ? (a1[2:0] - 3'd7) : a1[2:0];
        d    = (r7n >= a1m7) ? (r7n - a1m7) : (r7n + 3'd7 - a1m7);
        // 4*d mod 7
        case (d)
            3'd0:    e = 3'd0;
            3'd1:    e = 3'd4;
            3'd2:    e = 3'd1;
            3'd3:    e = 3'd5;
            3'd4:    e = 3'd2;
            3'd5:    e = 3'd6;
            default: e = 3'd3;
        endcase
        a2m7 = (a2 == 3'd7) ? 3'd0 : a2;
        a3   = (e >= a2m7) ? (e - a2m7) : (e + 3'd7 - a2m7);
        return {a3, a2, a1};
    endfunction

    logic [9:0] w_x;
    logic [9:0] w_y;
    logic       w_lt;
    logic       w_eq;
    logic       w_gt;

    logic       r_le;
    logic       r_eq;
    logic       r_gr;
    logic       r_out_valid;

    assign w_x  = mixed_radix(x1, x2, x3);
    assign w_y  = mixed_radix(y1, y2, y3);
    assign w_lt = (w_x < w_y);
    assign w_eq = (w_x == w_y);
    assign w_gt = (w_x > w_y);

`ifdef RNS_CMP_RANGE_CHECK_EN
    logic w_range_err;
    logic r_range_err;

    assign w_range_err = (x1 > 4'd8) | (y1 > 4'd8) | (x3 == 3'd7) | (y3 == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (in_valid) begin
            r_range_err <= w_range_err;
        end
    end

    assign range_err = r_range_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_le        <= 1'b0;
            r_eq        <= 1'b0;
            r_gr        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
`ifdef RNS_CMP_RANGE_CHECK_EN
                if (w_range_err) begin
                    r_le <= 1'b0;
                    r_eq <= 1'b0;
                    r_gr <= 1'b0;
                end else begin
                    r_le <= w_lt;
                    r_eq <= w_eq;
                    r_gr <= w_gt;
                end
`else
                r_le <= w_lt;
                r_eq <= w_eq;
                r_gr <= w_gt;
`endif
            end
        end
    end

    assign le        = r_le;
    assign eq        = r_eq;
    assign gr        = r_gr;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_rns_compare_9_8_7.sv
// ============================================================================
// Module   : tb_rns_compare_9_8_7
// Brief    : Directed self-checking bench for rns_compare_9_8_7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rns_compare_9_8_7;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] x1;
    logic [2:0] x2;
    logic [2:0] x3;
    logic [3:0] y1;
    logic [2:0] y2;
    logic [2:0] y3;
    logic       le;
    logic       eq;
    logic       gr;
    logic       out_valid;
    logic       range_err;

    int errors = 0;
    int checks = 0;

    // Flags the DUT should be holding across bubbles: {le, eq, gr}
    logic [2:0] held;

    rns_compare_9_8_7 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .le        (le),
        .eq        (eq),
        .gr        (gr),
`ifdef RNS_CMP_RANGE_CHECK_EN
        .range_err (range_err),
`endif
        .out_valid (out_valid)
    );

`ifndef RNS_CMP_RANGE_CHECK_EN
    assign range_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Observed/expected layout: {range_err, out_valid, le, eq, gr}
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {range_err, out_valid, le, eq, gr};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic apply_raw(input logic v,
                             input logic [3:0] a1, input logic [2:0] a2, input logic [2:0] a3,
                             input logic [3:0] b1, input logic [2:0] b2, input logic [2:0] b3);
        @(negedge clk);
        in_valid = v;
        x1 = a1; x2 = a2; x3 = a3;
        y1 = b1; y2 = b2; y3 = b3;
        @(posedge clk);
        #1;
    endtask

    task automatic step_int(input string tag, input logic v, input int xv, input int yv);
        logic [2:0] f;
        apply_raw(v, 4'(xv % 9), 3'(xv % 8), 3'(xv % 7),
                     4'(yv % 9), 3'(yv % 8), 3'(yv % 7));
        if (v) begin
            f = {xv < yv, xv == yv, xv > yv};
            held = f;
        end
        chk(tag, {1'b0, v, held});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        x1 = '0; x2 = '0; x3 = '0;
        y1 = '0; y2 = '0; y3 = '0;
        held = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 5'b00000);

        step_int("x0_y503", 1'b1, 0, 503);
        step_int("x503_y0", 1'b1, 503, 0);
        step_int("x251_y251", 1'b1, 251, 251);
        step_int("x251_y252", 1'b1, 251, 252);
        step_int("x252_y251", 1'b1, 252, 251);

        step_int("bubble_v1", 1'b1, 10, 20);
        step_int("bubble_hold", 1'b0, 400, 3);
        step_int("bubble_v2", 1'b1, 30, 5);

        for (int i = 0; i <= 503; i++) step_int("sweep_opp", 1'b1, i, 503 - i);
        for (int i = 0; i <= 503; i++) step_int("sweep_eq", 1'b1, i, i);
        for (int i = 0; i <= 503; i++) step_int("sweep_mirror", 1'b1, 503 - i, i);

        // 12 on x1 reduces to 3, so X looks like 336 = (3,0,0)
`ifdef RNS_CMP_RANGE_CHECK_EN
        apply_raw(1'b1, 4'd12, 3'd0, 3'd0, 4'd3, 3'd0, 3'd0);
        chk("range_x1_12", 5'b11000);
        apply_raw(1'b1, 4'd0, 3'd0, 3'd0, 4'd0, 3'd0, 3'd7);
        chk("range_y3_7", 5'b11000);
        held = 3'b000;
`else
        apply_raw(1'b1, 4'd12, 3'd0, 3'd0, 4'd3, 3'd0, 3'd0);
        chk("reduce_x1_12", 5'b01010);
        apply_raw(1'b1, 4'd0, 3'd0, 3'd7, 4'd0, 3'd0, 3'd0);
        chk("reduce_x3_7", 5'b01010);
        apply_raw(1'b1, 4'd12, 3'd0, 3'd0, 4'd1, 3'd0, 3'd0);
        chk("reduce_x1_12_gt", 5'b01001);
        held = 3'b001;
`endif
        step_int("post_range", 1'b1, 100, 200);

        // Mid-stream asynchronous reset with a sample in flight
        @(negedge clk);
        in_valid = 1'b1;
        x1 = 4'd8; x2 = 3'd7; x3 = 3'd6;
        y1 = 4'd0; y2 = 3'd0; y3 = 3'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 5'b00000);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_release_1", 5'b00000);
        @(posedge clk);
        #1;
        chk("after_release_2", 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
